lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Load/store sequencer between the main instruction decoder and the data-memory bus. When the decoder flags a memory instruction, the block stalls the PC, runs one request/acknowledge transaction on the data bus, and formats store byte-enables and load data by access size. It releases the PC after the access retires, or after a fault for misaligned, illegal or timed-out accesses. It sits beside the ALU in the single-issue core and owns the only path to data memory.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles spent waiting for bus_ack before a fault (≥2).

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  synchronous reset, active-low
- mem_req  in  1  decoder: current instruction is a load or store
- mem_we  in  1  decoder: 1 = store, 0 = load
- mem_size  in  3  decoder: func3 of the instruction
- mem_addr  in  32  byte address from ALU
- mem_wdata  in  32  store data (rs2)
- enpc_in  in  1  decoder PC enable
- enpc_out  out  1  gated PC enable to PC register
- stall  out  1  instruction held in place this cycle
- rd_data  out  32  formatted load result
- rd_valid  out  1  rd_data valid, register-file write allowed
- fault  out  1  access retired with error
- bus_req  out  1  bus request
- bus_we  out  1  bus write
- bus_be  out  4  byte enables
- bus_addr  out  32  word-aligned address ({mem_addr[31:2],2'b00})
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  bus completion strobe, one cycle
- bus_rdata  in  32  read data, valid with bus_ack

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: when mem_req=1, the block latches we, size, addr and wdata.
  - Legal access: go to REQ.
  - Illegal access: go to DONE with the fault bit set. No bus traffic.
- Illegal access means any of:
  - size ∈ {3,6,7};
  - store with size ∈ {4,5};
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0.
- REQ: bus_req=1, and all bus_* outputs hold steady from the latched values.
  - On bus_ack: capture bus_rdata, go to DONE.
  - Timeout counter starts at 0 on entry and increments each cycle without ack. If it reaches TIMEOUT-1 without ack: go to DONE with fault set and data 0.
- DONE: one cycle. Instruction retires; next state IDLE.
- stall = (state==IDLE & mem_req) | (state==REQ). It is 0 in DONE.
- enpc_out = enpc_in & ~stall.
- rd_valid = DONE & ~we & ~fault. fault is 1 only in DONE.
- Byte enables:
  - byte: 1<<addr[1:0];
  - half: addr[1] ? 4'b1100 : 4'b0011;
  - word: 4'b1111.
- Store lanes: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- Load extract: select the lane by addr[1:0], then extend:
  - size 0: sign-extend byte;
  - size 1: sign-extend half;
  - size 2: word as-is;
  - size 4: zero-extend byte;
  - size 5: zero-extend half.
- rd_data holds its value until the next DONE.

## Timing
- Reset (rst_n=0 at a clock edge) gives:
  - state IDLE;
  - bus_req, bus_we, fault, rd_valid = 0;
  - bus_be = 0, bus_addr = 0, bus_wdata = 0, rd_data = 0.
  - stall and enpc_out still follow their combinational equations.
- Minimum legal access is 3 cycles. With the instruction presented in cycle 0 and bus_ack in cycle 1:
  - cycle 0: IDLE, stall=1;
  - cycle 1: REQ, stall=1;
  - cycle 2: DONE, enpc_out=enpc_in.
- Each extra wait cycle adds one stall cycle.
- Illegal access is 2 cycles: stall in cycle 0, DONE with fault in cycle 1.
- Timeout: bus_req high for exactly TIMEOUT cycles, then DONE with fault.
- bus_ack outside REQ is ignored, with no state or data change.
- mem_req/addr changes during REQ are ignored because inputs were latched.
- Reset during REQ: bus_req drops at that edge and the transaction is abandoned.
- mem_req=0 in DONE: return to IDLE with no stall.
- Back-to-back memory instructions: the next one is sampled in IDLE the cycle after DONE.

## Test plan
- lw at addr 0x100, bus_rdata=0xDEADBEEF with ack in cycle 1:
  - bus_be=1111 and bus_addr=0x100;
  - rd_data=0xDEADBEEF, rd_valid=1 in cycle 2;
  - stall high exactly cycles 0–1.
- Loads at addr 0x103 with bus_rdata=0x80FF7F00:
  - lb: rd_data=0xFFFFFF80;
  - lbu: rd_data=0x00000080.
- Loads at addr 0x102 with the same data:
  - lh: rd_data=0xFFFF80FF;
  - lhu: rd_data=0x000080FF.
- sb at addr 0x101 with wdata=0x12345678: bus_we=1, bus_be=0010, bus_wdata=0x78787878, rd_valid=0 in DONE.
- sh at addr 0x102: bus_be=1100, bus_wdata=0x56785678.
- lw at addr 0x102, then lh at 0x001:
  - each gives fault=1 in cycle 1;
  - bus_req never rises;
  - stall high for 1 cycle only.
- TIMEOUT=16 with no ack: bus_req high 16 cycles, then DONE with fault=1 and rd_valid=0. Next, reset asserted in cycle 3 of a new REQ: bus_req=0 and state IDLE next cycle; a later ack is ignored.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: stalls the PC, runs one request/ack data-bus transaction,
// formats byte-enables, store lanes and load data by access size.
module lsu_mem_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [2:0]  mem_size,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        enpc_in,
   output logic        enpc_out,
   output logic        stall,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        fault,
   output logic        bus_req,
   output logic        bus_we,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t        state;
   logic          we_q;
   logic [2:0]    size_q;
   logic [1:0]    off_q;
   logic [CW-1:0] cnt;

   logic          illegal;
   logic [3:0]    be_new;
   logic [31:0]   wdata_new;
   logic [7:0]    bsel;
   logic [15:0]   hsel;
   logic [31:0]   ld_fmt;

   always_comb begin
      stall    = (state == IDLE && mem_req) || (state == REQ);
      enpc_out = enpc_in & ~stall;
   end

   // size[2] marks the unsigned load variants, which have no store form
   always_comb begin
      illegal = 1'b0;
      case (mem_size)
         3'd0, 3'd4: illegal = mem_we && mem_size[2];
         3'd1, 3'd5: illegal = mem_addr[0] || (mem_we && mem_size[2]);
         3'd2:       illegal = (mem_addr[1:0] != 2'b00);
         default:    illegal = 1'b1;
      endcase
   end

   always_comb begin
      be_new    = 4'b1111;
      wdata_new = mem_wdata;
      case (mem_size[1:0])
         2'd0: begin
            be_new    = 4'b0001 << mem_addr[1:0];
            wdata_new = {4{mem_wdata[7:0]}};
         end
         2'd1: begin
            be_new    = mem_addr[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{mem_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      bsel   = bus_rdata[{off_q, 3'b000} +: 8];
      hsel   = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      ld_fmt = bus_rdata;
      case (size_q)
         3'd0:    ld_fmt = {{24{bsel[7]}}, bsel};
         3'd1:    ld_fmt = {{16{hsel[15]}}, hsel};
         3'd4:    ld_fmt = {24'b0, bsel};
         3'd5:    ld_fmt = {16'b0, hsel};
         default: ld_fmt = bus_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         size_q    <= 3'd0;
         off_q     <= 2'd0;
         cnt       <= '0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_be    <= 4'b0;
         bus_addr  <= 32'b0;
         bus_wdata <= 32'b0;
         rd_data   <= 32'b0;
         rd_valid  <= 1'b0;
         fault     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               rd_valid <= 1'b0;
               fault    <= 1'b0;
               if (mem_req) begin
                  we_q   <= mem_we;
                  size_q <= mem_size;
                  off_q  <= mem_addr[1:0];
                  if (illegal) begin
                     state   <= DONE;
                     fault   <= 1'b1;
                     rd_data <= 32'b0;
                  end else begin
                     state     <= REQ;
                     cnt       <= '0;
                     bus_req   <= 1'b1;
                     bus_we    <= mem_we;
                     bus_be    <= be_new;
                     bus_addr  <= {mem_addr[31:2], 2'b00};
                     bus_wdata <= wdata_new;
                  end
               end
            end
            REQ: begin
               if (bus_ack) begin
                  state    <= DONE;
                  bus_req  <= 1'b0;
                  bus_we   <= 1'b0;
                  rd_data  <= ld_fmt;
                  rd_valid <= ~we_q;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  state   <= DONE;
                  bus_req <= 1'b0;
                  bus_we  <= 1'b0;
                  fault   <= 1'b1;
                  rd_data <= 32'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               state    <= IDLE;
               rd_valid <= 1'b0;
               fault    <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: hand-computed vectors checked with immediate assertions.
module tb_lsu_mem_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_req, mem_we;
   logic [2:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic        enpc_in, enpc_out, stall;
   logic [31:0] rd_data;
   logic        rd_valid, fault;
   logic        bus_req, bus_we;
   logic [3:0]  bus_be;
   logic [31:0] bus_addr, bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int passed = 0;
   int total  = 0;

   // values captured by the access tasks
   logic        s0, s1, s2, e0, e2, breq0, breq1, bwe, rv, flt;
   logic [3:0]  bbe;
   logic [31:0] badr, bwd, rd;

   lsu_mem_ctrl #(.TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
      .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .enpc_in(enpc_in), .enpc_out(enpc_out), .stall(stall),
      .rd_data(rd_data), .rd_valid(rd_valid), .fault(fault),
      .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // legal access, ack in cycle 1; address scrambled in cycle 1 to prove latching
   task automatic issue(input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdat);
      @(negedge clk);
      mem_req = 1'b1; mem_we = we; mem_size = sz; mem_addr = a; mem_wdata = wd; bus_ack = 1'b0;
      #1 s0 = stall; e0 = enpc_out; breq0 = bus_req;
      @(negedge clk);
      mem_req = 1'b0; mem_addr = 32'hFFFF_FFFF; bus_ack = 1'b1; bus_rdata = rdat;
      #1 s1 = stall; breq1 = bus_req; bwe = bus_we; bbe = bus_be; badr = bus_addr; bwd = bus_wdata;
      @(negedge clk);
      bus_ack = 1'b0;
      #1 s2 = stall; e2 = enpc_out; rv = rd_valid; rd = rd_data; flt = fault;
   endtask

   task automatic issue_bad(input logic we, input logic [2:0] sz, input logic [31:0] a);
      @(negedge clk);
      mem_req = 1'b1; mem_we = we; mem_size = sz; mem_addr = a; bus_ack = 1'b0;
      #1 s0 = stall; breq0 = bus_req;
      @(negedge clk);
      mem_req = 1'b0;
      #1 s1 = stall; breq1 = bus_req; flt = fault; rv = rd_valid;
   endtask

   initial begin
      int n;
      rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_size = 3'd0; mem_addr = 32'h0;
      mem_wdata = 32'h0; enpc_in = 1'b1; bus_ack = 1'b0; bus_rdata = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
      chk("rst_bus_be", {28'b0, bus_be}, 32'd0);
      chk("rst_rd_data", rd_data, 32'h0);
      chk("rst_fault_rv", {30'b0, fault, rd_valid}, 32'd0);
      chk("rst_enpc_idle", {30'b0, stall, enpc_out}, 32'd1);
      mem_req = 1'b1;
      #1 chk("rst_stall_comb", {30'b0, stall, enpc_out}, 32'd2);
      mem_req = 1'b0;
      @(negedge clk); rst_n = 1'b1;

      // lw 0x100
      issue(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF);
      chk("lw_stall012", {29'b0, s0, s1, s2}, 32'b110);
      chk("lw_enpc", {30'b0, e0, e2}, 32'b01);
      chk("lw_busreq", {30'b0, breq0, breq1}, 32'b01);
      chk("lw_be", {28'b0, bbe}, 32'hF);
      chk("lw_addr", badr, 32'h100);
      chk("lw_rd", rd, 32'hDEADBEEF);
      chk("lw_rv_flt", {30'b0, rv, flt}, 32'b10);

      // back-to-back byte/half loads
      issue(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF7F00);
      chk("lb_rd", rd, 32'hFFFFFF80);
      chk("lb_addr", badr, 32'h100);
      chk("lb_be", {28'b0, bbe}, 32'h8);
      issue(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF7F00);
      chk("lbu_rd", rd, 32'h00000080);
      issue(1'b0, 3'd1, 32'h102, 32'h0, 32'h80FF7F00);
      chk("lh_rd", rd, 32'hFFFF80FF);
      issue(1'b0, 3'd5, 32'h102, 32'h0, 32'h80FF7F00);
      chk("lhu_rd", rd, 32'h000080FF);
      chk("lhu_be", {28'b0, bbe}, 32'hC);

      // stores
      issue(1'b1, 3'd0, 32'h101, 32'h12345678, 32'h0);
      chk("sb_we", {31'b0, bwe}, 32'd1);
      chk("sb_be", {28'b0, bbe}, 32'h2);
      chk("sb_wdata", bwd, 32'h78787878);
      chk("sb_rv", {30'b0, rv, flt}, 32'b00);
      issue(1'b1, 3'd1, 32'h102, 32'h12345678, 32'h0);
      chk("sh_be", {28'b0, bbe}, 32'hC);
      chk("sh_wdata", bwd, 32'h56785678);

      // misaligned accesses fault without bus traffic
      issue_bad(1'b0, 3'd2, 32'h102);
      chk("lw_mis", {27'b0, s0, s1, breq0, breq1, flt}, 32'b10001);
      issue_bad(1'b0, 3'd1, 32'h001);
      chk("lh_mis", {27'b0, s0, s1, breq0, breq1, flt}, 32'b10001);
      issue_bad(1'b1, 3'd4, 32'h100);
      chk("sbu_ill", {30'b0, flt, rv}, 32'b10);

      // timeout: no ack
      @(negedge clk);
      mem_req = 1'b1; mem_we = 1'b0; mem_size = 3'd2; mem_addr = 32'h200; bus_ack = 1'b0;
      @(negedge clk); mem_req = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (!bus_req) break;
         n++;
         @(negedge clk);
      end
      chk("to_cycles", n, 32'd16);
      chk("to_fault_rv", {30'b0, fault, rd_valid}, 32'b10);
      chk("to_rd", rd_data, 32'h0);

      // reset in cycle 3 of a new REQ, then a stray ack
      @(negedge clk);
      mem_req = 1'b1; mem_size = 3'd2; mem_addr = 32'h300;
      @(negedge clk); mem_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 chk("rr_busreq_before", {31'b0, bus_req}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      #1 chk("rr_after", {29'b0, bus_req, stall, fault}, 32'd0);
      rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
      @(negedge clk);
      bus_ack = 1'b0;
      #1 chk("stray_ack", {29'b0, bus_req, rd_valid, fault}, 32'd0);
      chk("stray_rd", rd_data, 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
